// File: rtl/n64_pkg.sv
`default_nettype none
// ============================================================================
// Module  : n64_pkg
// Purpose : Shared constants, FSM encoding and timing helpers for the N64
//           controller-side responder.
// Revision: 1.0  initial release
// ============================================================================
package n64_pkg;

  localparam logic [7:0]  CMD_STATUS = 8'h00;
  localparam logic [7:0]  CMD_POLL   = 8'h01;
  localparam logic [7:0]  CMD_RESET  = 8'hFF;
  localparam logic [23:0] STATUS_ID  = 24'h050002;

  localparam logic [2:0] c_st_idle      = 3'd0;
  localparam logic [2:0] c_st_rx_bit    = 3'd1;
  localparam logic [2:0] c_st_rx_stop   = 3'd2;
  localparam logic [2:0] c_st_turnaround = 3'd3;
  localparam logic [2:0] c_st_tx_bit    = 3'd4;
  localparam logic [2:0] c_st_tx_stop   = 3'd5;
  localparam logic [2:0] c_st_quiet     = 3'd6;

  typedef enum logic [1:0] {
    REG_BUTTONS = 2'd0,
    REG_STATUS  = 2'd1,
    REG_CTRL    = 2'd2,
    REG_RSVD    = 2'd3
  } reg_sel_e;

  // Clock cycles spanned by a number of microseconds (one bit quarter = 1 us).
  function automatic int f_us_ticks(input int us, input int tpu);
    return us * tpu;
  endfunction

endpackage : n64_pkg
`default_nettype wire

// File: rtl/n64_bit_tx.sv
`default_nettype none
// ============================================================================
// Module  : n64_bit_tx
// Purpose : Serialises up to 32 bits MSB-first as N64 bit cells
//           ('0' = 3 us low, '1' = 1 us low, 4 us per cell).
// Revision: 1.0  initial release
// ============================================================================
module n64_bit_tx
  import n64_pkg::*;
#(
  parameter int TICKS_PER_US = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [31:0] i_word,
  input  logic [5:0]  i_len,
  output logic        o_drive_low,
  output logic        o_done
);

  localparam int c_tw = $clog2(4 * TICKS_PER_US + 1);
  localparam logic [c_tw-1:0] c_t1        = c_tw'(f_us_ticks(1, TICKS_PER_US));
  localparam logic [c_tw-1:0] c_t3        = c_tw'(f_us_ticks(3, TICKS_PER_US));
  localparam logic [c_tw-1:0] c_cell_last = c_tw'(f_us_ticks(4, TICKS_PER_US) - 1);

  logic            r_active;
  logic [c_tw-1:0] r_cnt;
  logic [31:0]     r_shift;
  logic [5:0]      r_left;
  logic            r_drive_low;
  logic            r_done;
  logic [c_tw-1:0] w_low_len;

  assign w_low_len   = r_shift[31] ? c_t1 : c_t3;
  assign o_drive_low = r_drive_low;
  assign o_done      = r_done;

  // The word is left-aligned on load so the current bit is always r_shift[31].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active    <= 1'b0;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_left      <= '0;
      r_drive_low <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_active    <= 1'b1;
        r_cnt       <= '0;
        r_left      <= i_len;
        r_shift     <= i_word << (6'd32 - i_len);
        r_drive_low <= 1'b0;
      end else if (r_active) begin
        r_drive_low <= (r_cnt < w_low_len);
        if (r_cnt == c_cell_last) begin
          r_cnt   <= '0;
          r_shift <= {r_shift[30:0], 1'b0};
          r_left  <= r_left - 6'd1;
          if (r_left == 6'd1) begin
            r_active <= 1'b0;
            r_done   <= 1'b1;
          end
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_drive_low <= 1'b0;
      end
    end
  end

endmodule : n64_bit_tx
`default_nettype wire

// File: rtl/n64_controller_responder.sv
`default_nettype none
// ============================================================================
// Module  : n64_controller_responder
// Purpose : APB3-controlled N64 controller emulation on an open-drain line.
// Revision: 1.0  initial release
// ============================================================================
module n64_controller_responder
  import n64_pkg::*;
#(
  parameter int TICKS_PER_US = 100,
  parameter int ABORT_US     = 5,
  parameter int QUIET_US     = 10
) (
  input  logic        PCLK,
  input  logic        PRESERN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [31:0] PRDATA,
  inout  wire         fab_pin
);

  localparam int c_tw = $clog2((QUIET_US + ABORT_US + 4) * TICKS_PER_US + 1);
  localparam logic [c_tw-1:0] c_sample  = c_tw'(f_us_ticks(2, TICKS_PER_US));
  localparam logic [c_tw-1:0] c_t2_last = c_tw'(f_us_ticks(2, TICKS_PER_US) - 1);
  localparam logic [c_tw-1:0] c_abort   = c_tw'(f_us_ticks(ABORT_US, TICKS_PER_US));
  localparam logic [c_tw-1:0] c_quiet_last = c_tw'(f_us_ticks(QUIET_US, TICKS_PER_US) - 1);

  logic [31:0]     r_buttons, r_shadow;
  logic            r_enable;
  logic [15:0]     r_poll;
  logic [7:0]      r_err;
  logic [2:0]      r_state;
  logic            r_meta, r_sync, r_prev;
  logic [c_tw-1:0] r_timer;
  logic [7:0]      r_shift;
  logic [2:0]      r_bitcnt;
  logic            r_stop_seen, r_tx_start, r_stop_low;

  logic     w_wr, w_busy, w_fall, w_known, w_rx_abort, w_rx_done;
  logic     w_tx_go, w_err_inc, w_poll_inc, w_clear, w_tx_low, w_tx_done;
  reg_sel_e w_sel;
  wire      w_unused = &{1'b0, PADDR[31:4], PADDR[1:0]};

  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;
  assign fab_pin = (w_tx_low | r_stop_low) ? 1'b0 : 1'bz;

  assign w_sel      = reg_sel_e'(PADDR[3:2]);
  assign w_wr       = PSEL & PENABLE & PWRITE;
  assign w_clear    = w_wr && (w_sel == REG_CTRL) && PWDATA[1];
  assign w_busy     = (r_state != c_st_idle);
  assign w_fall     = r_prev & ~r_sync;
  assign w_known    = (r_shift == CMD_STATUS) || (r_shift == CMD_POLL) || (r_shift == CMD_RESET);
  assign w_rx_abort = ((r_state == c_st_rx_bit) || (r_state == c_st_rx_stop)) &&
                      !w_fall && (r_timer >= c_abort);
  assign w_rx_done  = (r_state == c_st_rx_stop) && r_stop_seen && r_sync && !w_rx_abort;
  assign w_tx_go    = (r_state == c_st_turnaround) && (r_timer == c_t2_last);
  assign w_err_inc  = w_rx_abort | (w_rx_done & ~w_known);
  assign w_poll_inc = w_tx_go && (r_shift == CMD_POLL);

  always_comb begin
    PRDATA = '0;
    case (w_sel)
      REG_BUTTONS: PRDATA = r_buttons;
      REG_STATUS:  PRDATA = {7'd0, w_busy, r_err, r_poll};
      REG_CTRL:    PRDATA = {31'd0, r_enable};
      default:     PRDATA = '0;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      r_buttons <= '0;
      r_enable  <= 1'b0;
      r_poll    <= '0;
      r_err     <= '0;
    end else begin
      if (w_wr && (w_sel == REG_BUTTONS)) r_buttons <= PWDATA;
      if (w_wr && (w_sel == REG_CTRL))    r_enable  <= PWDATA[0];
      if (w_clear) begin
        r_poll <= '0;
        r_err  <= '0;
      end else begin
        if (w_poll_inc) r_poll <= r_poll + 16'd1;
        if (w_err_inc && (r_err != 8'hFF)) r_err <= r_err + 8'd1;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      r_meta      <= 1'b1;
      r_sync      <= 1'b1;
      r_prev      <= 1'b1;
      r_state     <= c_st_idle;
      r_timer     <= '0;
      r_shift     <= '0;
      r_bitcnt    <= '0;
      r_stop_seen <= 1'b0;
      r_shadow    <= '0;
      r_tx_start  <= 1'b0;
      r_stop_low  <= 1'b0;
    end else begin
      r_meta     <= fab_pin;
      r_sync     <= r_meta;
      r_prev     <= r_sync;
      r_tx_start <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (w_fall && r_enable) begin
            r_state  <= c_st_rx_bit;
            r_timer  <= '0;
            r_bitcnt <= '0;
          end
        end
        c_st_rx_bit: begin
          if (w_fall) begin
            r_timer <= '0;
          end else if (w_rx_abort) begin
            r_state <= c_st_quiet;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
            if (r_timer == c_sample) begin
              r_shift  <= {r_shift[6:0], r_sync};
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7) begin
                r_state     <= c_st_rx_stop;
                r_stop_seen <= 1'b0;
              end
            end
          end
        end
        c_st_rx_stop: begin
          if (w_fall) begin
            r_timer     <= '0;
            r_stop_seen <= 1'b1;
          end else if (w_rx_abort) begin
            r_state <= c_st_quiet;
            r_timer <= '0;
          end else if (w_rx_done) begin
            // Snapshot here so an APB write during the reply cannot tear it.
            r_timer  <= '0;
            r_shadow <= r_buttons;
            r_state  <= w_known ? c_st_turnaround : c_st_quiet;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        c_st_turnaround: begin
          if (w_tx_go) begin
            r_state    <= c_st_tx_bit;
            r_tx_start <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        c_st_tx_bit: begin
          if (w_tx_done) begin
            r_state    <= c_st_tx_stop;
            r_stop_low <= 1'b1;
            r_timer    <= '0;
          end
        end
        c_st_tx_stop: begin
          if (r_timer == c_t2_last) begin
            r_stop_low <= 1'b0;
            r_state    <= c_st_quiet;
            r_timer    <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        c_st_quiet: begin
          if (!r_sync) begin
            r_timer <= '0;
          end else if (r_timer == c_quiet_last) begin
            r_state <= c_st_idle;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  n64_bit_tx #(
    .TICKS_PER_US(TICKS_PER_US)
  ) u_bit_tx (
    .clk        (PCLK),
    .rst_n      (PRESERN),
    .i_start    (r_tx_start),
    .i_word     ((r_shift == CMD_POLL) ? r_shadow : {8'h00, STATUS_ID}),
    .i_len      ((r_shift == CMD_POLL) ? 6'd32 : 6'd24),
    .o_drive_low(w_tx_low),
    .o_done     (w_tx_done)
  );

endmodule : n64_controller_responder
`default_nettype wire

// File: tb/tb_n64_controller_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_n64_controller_responder
// Purpose : Console-side behavioural model and scoreboard for the responder.
// Revision: 1.0  initial release
// ============================================================================
module tb_n64_controller_responder;

  localparam logic [31:0] c_a_buttons = 32'h0;
  localparam logic [31:0] c_a_status  = 32'h4;
  localparam logic [31:0] c_a_ctrl    = 32'h8;
  localparam logic [31:0] c_a_rsvd    = 32'hC;

  logic        PCLK = 1'b0;
  logic        PRESERN = 1'b0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PADDR = '0, PWDATA = '0;
  wire         PREADY, PSLVERR;
  wire  [31:0] PRDATA;
  wire         fab_pin;
  logic        con_low = 1'b0;

  assign fab_pin = con_low ? 1'b0 : 1'bz;
  pullup (fab_pin);

  always #5 PCLK = ~PCLK;

  n64_controller_responder #(
    .TICKS_PER_US(4),
    .ABORT_US    (5),
    .QUIET_US    (10)
  ) dut (
    .PCLK   (PCLK),
    .PRESERN(PRESERN),
    .PSEL   (PSEL),
    .PENABLE(PENABLE),
    .PWRITE (PWRITE),
    .PADDR  (PADDR),
    .PWDATA (PWDATA),
    .PREADY (PREADY),
    .PSLVERR(PSLVERR),
    .PRDATA (PRDATA),
    .fab_pin(fab_pin)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_buttons = '0;
  int          m_poll = 0;
  int          m_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge PCLK);
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = addr; PWDATA = data;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge PCLK);
    PADDR = addr; PSEL = 1'b1;
    #1 data = PRDATA;
    PSEL = 1'b0;
  endtask

  task automatic set_buttons(input logic [31:0] v);
    apb_write(c_a_buttons, v);
    m_buttons = v;
  endtask

  // Console bit cells: '1' = 1 us low, '0' = 3 us low, 4 us (16 cycles) each.
  task automatic send_bits(input logic [31:0] value, input int nbits);
    int low;
    for (int i = nbits - 1; i >= 0; i--) begin
      low = value[i] ? 4 : 12;
      con_low = 1'b1;
      repeat (low) @(negedge PCLK);
      con_low = 1'b0;
      repeat (16 - low) @(negedge PCLK);
    end
  endtask

  task automatic send_cmd(input logic [7:0] cmd);
    @(negedge PCLK);
    send_bits({24'd0, cmd}, 8);
    con_low = 1'b1;
    repeat (4) @(negedge PCLK);
    con_low = 1'b0;
  endtask

  // Measures every low pulse of a reply; the final pulse is the stop bit.
  task automatic receive(output int n, output logic [31:0] bits, output int stop_len);
    int lows[$];
    int w;
    n = 0; bits = '0; stop_len = 0; w = 0;
    while (fab_pin !== 1'b0 && w < 200) begin
      @(negedge PCLK);
      w++;
    end
    if (fab_pin === 1'b0) begin
      for (int k = 0; k < 40; k++) begin
        int lo, hi;
        lo = 0; hi = 0;
        while (fab_pin === 1'b0 && lo < 100) begin @(negedge PCLK); lo++; end
        lows.push_back(lo);
        while (fab_pin === 1'b1 && hi < 30) begin @(negedge PCLK); hi++; end
        if (hi >= 30) break;
      end
      n = lows.size() - 1;
      stop_len = lows[n];
      for (int i = 0; i < n; i++) bits = {bits[30:0], (lows[i] <= 6)};
    end
  endtask

  task automatic wait_idle();
    logic [31:0] st;
    st = 32'hFFFF_FFFF;
    for (int k = 0; k < 400; k++) begin
      apb_read(c_a_status, st);
      if (!st[24]) break;
    end
    check_val("idle_reached", {63'd0, st[24]}, 64'd0);
  endtask

  task automatic do_txn(input logic [7:0] cmd, input bit mid_write, input logic [31:0] new_val);
    int          n, stop_len, exp_n;
    logic [31:0] bits, st, exp_bits;
    bit          answers;
    answers  = (cmd == 8'h00) || (cmd == 8'h01) || (cmd == 8'hFF);
    exp_bits = (cmd == 8'h01) ? m_buttons : 32'h0005_0002;
    exp_n    = !answers ? 0 : (cmd == 8'h01) ? 32 : 24;
    send_cmd(cmd);
    repeat (2) @(negedge PCLK);
    apb_read(c_a_status, st);
    check_val("busy_after_cmd", {63'd0, st[24]}, 64'd1);
    fork
      receive(n, bits, stop_len);
      begin
        if (mid_write) begin
          repeat (150) @(negedge PCLK);
          apb_write(c_a_buttons, new_val);
        end
      end
    join
    check_val("resp_len", n, exp_n);
    if (answers) begin
      check_val("resp_bits", bits, exp_bits);
      check_val("stop_len", stop_len, 8);
    end
    if (cmd == 8'h01) m_poll++;
    if (!answers) m_err++;
    if (mid_write) m_buttons = new_val;
    wait_idle();
    apb_read(c_a_status, st);
    check_val("status", st, {8'd0, m_err[7:0], m_poll[15:0]});
  endtask

  initial begin
    logic [31:0] rd;
    int          n, stop_len, r, w;
    logic [31:0] bits;
    logic [7:0]  cmd;

    repeat (3) @(negedge PCLK);
    check_val("pready", {63'd0, PREADY}, 64'd1);
    check_val("pslverr", {63'd0, PSLVERR}, 64'd0);
    check_val("reset_pin", {63'd0, fab_pin}, 64'd1);
    apb_read(c_a_buttons, rd); check_val("rst_buttons", rd, 0);
    apb_read(c_a_status, rd);  check_val("rst_status", rd, 0);
    apb_read(c_a_ctrl, rd);    check_val("rst_ctrl", rd, 0);
    @(negedge PCLK);
    PRESERN = 1'b1;

    apb_write(c_a_ctrl, 32'h1);
    set_buttons(32'h9000_7F81);
    do_txn(8'h01, 1'b0, 0);
    do_txn(8'hFF, 1'b0, 0);
    do_txn(8'h00, 1'b0, 0);
    do_txn(8'h02, 1'b0, 0);

    // Truncated command: 4 bits then the line idles.
    @(negedge PCLK);
    send_bits(32'hA, 4);
    receive(n, bits, stop_len);
    check_val("abort_no_drive", n, 0);
    m_err++;
    wait_idle();
    apb_read(c_a_status, rd);
    check_val("abort_status", rd, {8'd0, m_err[7:0], m_poll[15:0]});
    do_txn(8'h01, 1'b0, 0);

    do_txn(8'h01, 1'b1, 32'h1234_0000);
    do_txn(8'h01, 1'b0, 0);

    apb_write(c_a_rsvd, $urandom);
    apb_read(c_a_rsvd, rd); check_val("rsvd_read", rd, 0);

    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 1) == 1) set_buttons($urandom);
      r = $urandom_range(0, 3);
      cmd = (r == 0) ? 8'h00 : (r == 1) ? 8'h01 : (r == 2) ? 8'hFF : 8'($urandom_range(2, 254));
      do_txn(cmd, 1'b0, 0);
    end

    apb_write(c_a_ctrl, 32'h3);
    m_poll = 0; m_err = 0;
    apb_read(c_a_status, rd); check_val("clear_status", rd, 0);
    apb_read(c_a_ctrl, rd);   check_val("clear_ctrl", rd, 1);
    apb_read(c_a_buttons, rd); check_val("buttons_rb", rd, m_buttons);

    // Reset while the responder is actively pulling the line low.
    set_buttons(32'h0000_0000);
    send_cmd(8'h01);
    w = 0;
    while (fab_pin !== 1'b0 && w < 300) begin @(negedge PCLK); w++; end
    check_val("tx_started", {63'd0, fab_pin}, 64'd0);
    @(negedge PCLK);
    PRESERN = 1'b0;
    #1 check_val("reset_release", {63'd0, fab_pin}, 64'd1);
    apb_read(c_a_status, rd);  check_val("midrst_status", rd, 0);
    apb_read(c_a_buttons, rd); check_val("midrst_buttons", rd, 0);
    @(negedge PCLK);
    PRESERN = 1'b1;
    m_buttons = '0; m_poll = 0; m_err = 0;
    repeat (60) @(negedge PCLK);

    send_cmd(8'h01);
    repeat (2) @(negedge PCLK);
    apb_read(c_a_status, rd);
    check_val("disabled_busy", {63'd0, rd[24]}, 64'd0);
    receive(n, bits, stop_len);
    check_val("disabled_no_resp", n, 0);
    apb_read(c_a_status, rd); check_val("disabled_status", rd, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule : tb_n64_controller_responder
`default_nettype wire
